// File: rtl/soc_bus_fabric_pkg.sv
// Shared types and constants for the FemtoRV32 local-bus fabric.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } bus_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    localparam int SLV_MEM  = 0;
    localparam int SLV_GPIO = 1;
    localparam int SLV_UART = 2;

    localparam logic [15:0] SLAVE_BASE_DEFAULT = {4'h3, 4'h2, 4'h1, 4'h0};

endpackage

// File: rtl/soc_bus_fabric_if.sv
// CPU memory port plus local-bus slave signals; the fabric uses the master view.
interface soc_bus_fabric_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic [3:0]               mem_wmask;
    logic                     mem_rstrb;
    logic [31:0]              mem_rdata;
    logic                     mem_rbusy;
    logic                     mem_wbusy;

    logic [31:0]              s_addr;
    logic [31:0]              s_wdata;
    logic [3:0]               s_wstrb;
    logic [NUM_SLAVES-1:0]    s_ren;
    logic [NUM_SLAVES-1:0]    s_wen;
    logic [NUM_SLAVES*32-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]    s_rvalid;
    logic [NUM_SLAVES-1:0]    s_wready;

    logic                     err_clr;
    logic                     err_valid;
    logic [31:0]              err_addr;
    logic                     err_is_wr;

    modport master (
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output mem_rdata, mem_rbusy, mem_wbusy,
        output s_addr, s_wdata, s_wstrb, s_ren, s_wen,
        input  s_rdata, s_rvalid, s_wready,
        input  err_clr,
        output err_valid, err_addr, err_is_wr
    );

    modport slave (
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  mem_rdata, mem_rbusy, mem_wbusy,
        input  s_addr, s_wdata, s_wstrb, s_ren, s_wen,
        output s_rdata, s_rvalid, s_wready,
        output err_clr,
        input  err_valid, err_addr, err_is_wr
    );

endinterface

// File: rtl/soc_bus_fabric_addr_decode.sv
// Address-nibble decoder: one-hot hit, hit index and unmapped flag, lowest index wins.
module bus_addr_decode
    import soc_bus_pkg::*;
#(
    parameter int                      NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*4-1:0] SLAVE_BASE = SLAVE_BASE_DEFAULT,
    parameter int                      IW         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [3:0]            nibble_i,
    output logic [NUM_SLAVES-1:0] hit_o,
    output logic [IW-1:0]         idx_o,
    output logic                  unmapped_o
);

    logic found;

    // Scan from the top so the lowest matching index overwrites any higher one.
    always_comb begin
        hit_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (SLAVE_BASE[4*i +: 4] == nibble_i) begin
                hit_o    = '0;
                hit_o[i] = 1'b1;
                idx_o    = IW'(i);
                found    = 1'b1;
            end
        end
        unmapped_o = ~found;
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master bus fabric: decodes CPU accesses, stalls until the slave answers, records errors.
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int                      NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*4-1:0] SLAVE_BASE = SLAVE_BASE_DEFAULT,
    parameter int                      TIMEOUT    = 255,
    parameter logic [31:0]             ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    soc_bus_fabric_if.master bus
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    bus_state_t            state_q, state_d;
    logic [IW-1:0]         sel_q, sel_d;
    logic [31:0]           addr_q, addr_d;
    logic                  unmapped_q, unmapped_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_valid_q, err_valid_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic                  err_is_wr_q, err_is_wr_d;

    logic [NUM_SLAVES-1:0] hit;
    logic [IW-1:0]         hit_idx;
    logic                  unmapped;
    logic                  wr_req, rd_req;
    logic                  rvalid_sel, wready_sel;
    logic [31:0]           rdata_sel;
    logic                  timeout_hit, fail_now;
    logic                  err_evt, err_wr;

    bus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .IW         (IW)
    ) u_decode (
        .nibble_i   (bus.mem_addr[31:28]),
        .hit_o      (hit),
        .idx_o      (hit_idx),
        .unmapped_o (unmapped)
    );

    assign wr_req      = |bus.mem_wmask;
    assign rd_req      = bus.mem_rstrb & ~wr_req;
    assign rvalid_sel  = bus.s_rvalid[sel_q] & ~unmapped_q;
    assign wready_sel  = bus.s_wready[sel_q] & ~unmapped_q;
    assign rdata_sel   = bus.s_rdata[32*sel_q +: 32];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign fail_now    = unmapped_q | timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = (!unmapped && bus.s_wready[hit_idx]) ? IDLE : WR_WAIT;
                end else if (rd_req) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: if (rvalid_sel || fail_now) state_d = IDLE;
            WR_WAIT: if (wready_sel || fail_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are masked during reset so nothing leaks out while held in reset.
    always_comb begin
        bus.s_ren = '0;
        bus.s_wen = '0;
        if (reset_n && state_q == IDLE) begin
            if (wr_req) begin
                bus.s_wen = hit;
            end else if (rd_req) begin
                bus.s_ren = hit;
            end
        end
        bus.mem_rbusy = (state_q == RD_WAIT);
        bus.mem_wbusy = (state_q == WR_WAIT);
    end

    always_comb begin
        sel_d       = sel_q;
        addr_d      = addr_q;
        unmapped_d  = unmapped_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_evt     = 1'b0;
        err_wr      = 1'b0;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_is_wr_d = err_is_wr_q;

        case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    sel_d      = hit_idx;
                    addr_d     = bus.mem_addr;
                    unmapped_d = unmapped;
                    cnt_d      = '0;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (rvalid_sel) begin
                    rdata_d = rdata_sel;
                end else if (fail_now) begin
                    rdata_d = ERR_DATA;
                    err_evt = 1'b1;
                end
            end
            WR_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!wready_sel && fail_now) begin
                    err_evt = 1'b1;
                    err_wr  = 1'b1;
                end
            end
            default: ;
        endcase

        // A clear in the same cycle as a new error lets the new error in.
        if (err_evt && (!err_valid_q || bus.err_clr)) begin
            err_valid_d = 1'b1;
            err_addr_d  = addr_q;
            err_is_wr_d = err_wr;
        end else if (bus.err_clr) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q       <= '0;
            addr_q      <= '0;
            unmapped_q  <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_is_wr_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            unmapped_q  <= unmapped_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_is_wr_q <= err_is_wr_d;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.s_addr    = {4'h0, bus.mem_addr[27:0]};
    assign bus.s_wdata   = bus.mem_wdata;
    assign bus.s_wstrb   = bus.mem_wmask;
    assign bus.err_valid = err_valid_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.err_is_wr = err_is_wr_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: reads, writes, unmapped, timeout, error record and reset.
module tb_soc_bus_fabric;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    soc_bus_fabric_if #(.NUM_SLAVES(4)) bus ();

    soc_bus_fabric #(
        .NUM_SLAVES (4),
        .SLAVE_BASE ({4'h3, 4'h2, 4'h1, 4'h0}),
        .TIMEOUT    (8),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic atSample();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wmask, input logic rstrb);
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wmask = wmask;
        bus.mem_rstrb = rstrb;
    endtask

    task automatic quietBus();
        applyStimulus(32'h0, 32'h0, 4'h0, 1'b0);
        bus.s_rvalid = '0;
        bus.s_wready = '0;
        bus.err_clr  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        bus.s_rdata = '0;
        quietBus();

        // Reset values
        repeat (2) @(posedge clk);
        atSample();
        checkOutput("rst_rdata", bus.mem_rdata, 32'h0);
        checkOutput("rst_rbusy", 32'(bus.mem_rbusy), 32'h0);
        checkOutput("rst_wbusy", 32'(bus.mem_wbusy), 32'h0);
        checkOutput("rst_ren", 32'(bus.s_ren), 32'h0);
        checkOutput("rst_wen", 32'(bus.s_wen), 32'h0);
        checkOutput("rst_err_valid", 32'(bus.err_valid), 32'h0);
        checkOutput("rst_err_addr", bus.err_addr, 32'h0);
        checkOutput("rst_err_is_wr", 32'(bus.err_is_wr), 32'h0);
        nextCycle();
        reset_n = 1'b1;

        // Registered RAM read, k=1
        nextCycle();
        applyStimulus(32'h0000_0010, 32'h0, 4'h0, 1'b1);
        atSample();
        checkOutput("ram_ren", 32'(bus.s_ren), 32'h1);
        checkOutput("ram_rbusy_T", 32'(bus.mem_rbusy), 32'h0);
        checkOutput("ram_saddr", bus.s_addr, 32'h0000_0010);
        nextCycle();
        quietBus();
        bus.s_rvalid = 4'b0001;
        bus.s_rdata[31:0] = 32'h1234_5678;
        atSample();
        checkOutput("ram_rbusy_T1", 32'(bus.mem_rbusy), 32'h1);
        checkOutput("ram_ren_T1", 32'(bus.s_ren), 32'h0);
        nextCycle();
        quietBus();
        atSample();
        checkOutput("ram_rbusy_T2", 32'(bus.mem_rbusy), 32'h0);
        checkOutput("ram_rdata", bus.mem_rdata, 32'h1234_5678);

        // Slow UART read, rvalid at T+5, stale slave-0 rvalid at T+2
        nextCycle();
        applyStimulus(32'h2000_0004, 32'h0, 4'h0, 1'b1);
        atSample();
        checkOutput("uart_ren", 32'(bus.s_ren), 32'h4);
        checkOutput("uart_saddr", bus.s_addr, 32'h0000_0004);
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            quietBus();
            if (k == 2) begin
                bus.s_rvalid = 4'b0001;
                bus.s_rdata[31:0] = 32'h1111_1111;
            end
            if (k == 5) begin
                bus.s_rvalid = 4'b0100;
                bus.s_rdata[95:64] = 32'hCAFE_F00D;
            end
            atSample();
            checkOutput($sformatf("uart_rbusy_T%0d", k), 32'(bus.mem_rbusy), 32'h1);
        end
        nextCycle();
        quietBus();
        atSample();
        checkOutput("uart_rbusy_T6", 32'(bus.mem_rbusy), 32'h0);
        checkOutput("uart_rdata", bus.mem_rdata, 32'hCAFE_F00D);

        // Write with same-cycle wready
        nextCycle();
        applyStimulus(32'h1000_0000, 32'h0000_00A5, 4'b0001, 1'b0);
        bus.s_wready = 4'b0010;
        atSample();
        checkOutput("wr0_wen", 32'(bus.s_wen), 32'h2);
        checkOutput("wr0_wstrb", 32'(bus.s_wstrb), 32'h1);
        checkOutput("wr0_wdata", bus.s_wdata, 32'h0000_00A5);
        nextCycle();
        quietBus();
        atSample();
        checkOutput("wr0_wbusy", 32'(bus.mem_wbusy), 32'h0);

        // Write with wready at T+3
        nextCycle();
        applyStimulus(32'h1000_0000, 32'h0000_005A, 4'b0001, 1'b0);
        atSample();
        checkOutput("wr3_wen", 32'(bus.s_wen), 32'h2);
        checkOutput("wr3_wbusy_T", 32'(bus.mem_wbusy), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            quietBus();
            if (k == 3) bus.s_wready = 4'b0010;
            atSample();
            checkOutput($sformatf("wr3_wbusy_T%0d", k), 32'(bus.mem_wbusy), 32'h1);
            checkOutput($sformatf("wr3_wen_T%0d", k), 32'(bus.s_wen), 32'h0);
        end
        nextCycle();
        quietBus();
        atSample();
        checkOutput("wr3_wbusy_T4", 32'(bus.mem_wbusy), 32'h0);

        // Read and write together: write wins
        nextCycle();
        applyStimulus(32'h0000_0020, 32'h0, 4'b1111, 1'b1);
        bus.s_wready = 4'b0001;
        atSample();
        checkOutput("rw_wen", 32'(bus.s_wen), 32'h1);
        checkOutput("rw_ren", 32'(bus.s_ren), 32'h0);
        nextCycle();
        quietBus();
        atSample();
        checkOutput("rw_rbusy", 32'(bus.mem_rbusy), 32'h0);
        checkOutput("rw_wbusy", 32'(bus.mem_wbusy), 32'h0);

        // Unmapped read
        nextCycle();
        applyStimulus(32'hF000_0000, 32'h0, 4'h0, 1'b1);
        atSample();
        checkOutput("um_ren", 32'(bus.s_ren), 32'h0);
        nextCycle();
        quietBus();
        atSample();
        checkOutput("um_rbusy_T1", 32'(bus.mem_rbusy), 32'h1);
        nextCycle();
        atSample();
        checkOutput("um_rbusy_T2", 32'(bus.mem_rbusy), 32'h0);
        checkOutput("um_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
        checkOutput("um_err_valid", 32'(bus.err_valid), 32'h1);
        checkOutput("um_err_addr", bus.err_addr, 32'hF000_0000);
        checkOutput("um_err_is_wr", 32'(bus.err_is_wr), 32'h0);

        // Second error leaves the record unchanged
        nextCycle();
        applyStimulus(32'hE000_0000, 32'h0, 4'b0001, 1'b0);
        atSample();
        checkOutput("um2_wen", 32'(bus.s_wen), 32'h0);
        nextCycle();
        quietBus();
        atSample();
        checkOutput("um2_wbusy_T1", 32'(bus.mem_wbusy), 32'h1);
        nextCycle();
        atSample();
        checkOutput("um2_wbusy_T2", 32'(bus.mem_wbusy), 32'h0);
        checkOutput("um2_err_addr", bus.err_addr, 32'hF000_0000);
        checkOutput("um2_err_is_wr", 32'(bus.err_is_wr), 32'h0);

        // err_clr together with a new error records the new one
        nextCycle();
        applyStimulus(32'h9000_0000, 32'h0, 4'b0001, 1'b0);
        nextCycle();
        quietBus();
        bus.err_clr = 1'b1;
        nextCycle();
        quietBus();
        atSample();
        checkOutput("clr_new_valid", 32'(bus.err_valid), 32'h1);
        checkOutput("clr_new_addr", bus.err_addr, 32'h9000_0000);
        checkOutput("clr_new_is_wr", 32'(bus.err_is_wr), 32'h1);

        // Plain err_clr
        nextCycle();
        bus.err_clr = 1'b1;
        nextCycle();
        quietBus();
        atSample();
        checkOutput("clr_valid", 32'(bus.err_valid), 32'h0);

        // Timeout on silent slave 3, late rvalid at T+12
        nextCycle();
        applyStimulus(32'h3000_0000, 32'h0, 4'h0, 1'b1);
        atSample();
        checkOutput("to_ren", 32'(bus.s_ren), 32'h8);
        for (int k = 1; k <= 8; k++) begin
            nextCycle();
            quietBus();
            atSample();
            checkOutput($sformatf("to_rbusy_T%0d", k), 32'(bus.mem_rbusy), 32'h1);
        end
        nextCycle();
        atSample();
        checkOutput("to_rbusy_T9", 32'(bus.mem_rbusy), 32'h0);
        checkOutput("to_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
        checkOutput("to_err_valid", 32'(bus.err_valid), 32'h1);
        checkOutput("to_err_addr", bus.err_addr, 32'h3000_0000);
        repeat (2) nextCycle();
        nextCycle();
        bus.s_rvalid = 4'b1000;
        bus.s_rdata[127:96] = 32'h7777_7777;
        nextCycle();
        quietBus();
        atSample();
        checkOutput("late_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
        checkOutput("late_rbusy", 32'(bus.mem_rbusy), 32'h0);

        // Normal read after the timeout
        nextCycle();
        applyStimulus(32'h0000_0040, 32'h0, 4'h0, 1'b1);
        nextCycle();
        quietBus();
        bus.s_rvalid = 4'b0001;
        bus.s_rdata[31:0] = 32'h0BAD_C0DE;
        nextCycle();
        quietBus();
        atSample();
        checkOutput("post_to_rdata", bus.mem_rdata, 32'h0BAD_C0DE);
        checkOutput("post_to_rbusy", 32'(bus.mem_rbusy), 32'h0);

        // Asynchronous reset in RD_WAIT
        nextCycle();
        applyStimulus(32'h1000_0008, 32'h0, 4'h0, 1'b1);
        nextCycle();
        quietBus();
        atSample();
        checkOutput("mr_rbusy_pre", 32'(bus.mem_rbusy), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mr_rbusy", 32'(bus.mem_rbusy), 32'h0);
        checkOutput("mr_rdata", bus.mem_rdata, 32'h0);
        checkOutput("mr_err_valid", 32'(bus.err_valid), 32'h0);
        checkOutput("mr_err_addr", bus.err_addr, 32'h0);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        applyStimulus(32'h1000_000C, 32'h0, 4'h0, 1'b1);
        atSample();
        checkOutput("mr_next_ren", 32'(bus.s_ren), 32'h2);
        nextCycle();
        quietBus();
        bus.s_rvalid = 4'b0010;
        bus.s_rdata[63:32] = 32'h5A5A_5A5A;
        atSample();
        checkOutput("mr_next_rbusy", 32'(bus.mem_rbusy), 32'h1);
        nextCycle();
        quietBus();
        atSample();
        checkOutput("mr_next_rdata", bus.mem_rdata, 32'h5A5A_5A5A);
        checkOutput("mr_next_rbusy_done", 32'(bus.mem_rbusy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_bus_fabric.md
# soc_bus_fabric

Parametrised single-master bus fabric between the FemtoRV32 memory port and up to NUM_SLAVES local-bus slaves (RAM, GPIO, UART, and later ones). It decodes each access by address nibble and forwards one-cycle read and write strobes to the selected slave. It stalls the CPU through mem_rbusy/mem_wbusy until the slave answers, and returns a registered read word. Unmapped accesses and accesses that exceed a response timeout complete with an error word and latch an error record.

## Interface
- NUM_SLAVES, 4: number of slave ports, 1..8.
- SLAVE_BASE, {4'h3,4'h2,4'h1,4'h0}: packed NUM_SLAVES×4 bits; slave i owns addresses whose mem_addr[31:28] equals nibble i.
- TIMEOUT, 255: wait cycles before a forced error completion; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an error completion.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  in  32  CPU address.
- mem_wdata  in  32  CPU write data.
- mem_wmask  in  4  CPU byte write strobe; nonzero means a write request.
- mem_rstrb  in  1  CPU read request, one-cycle pulse.
- mem_rdata  out  32  registered read data to the CPU.
- mem_rbusy  out  1  read stall.
- mem_wbusy  out  1  write stall.
- s_addr  out  32  {4'h0, mem_addr[27:0]}, shared by all slaves.
- s_wdata  out  32  mem_wdata, shared.
- s_wstrb  out  4  mem_wmask, shared.
- s_ren  out  NUM_SLAVES  one-hot read pulse.
- s_wen  out  NUM_SLAVES  one-hot write pulse.
- s_rdata  in  NUM_SLAVES×32  slave read data; slave i occupies bits [32i+31:32i].
- s_rvalid  in  NUM_SLAVES  read data valid, one cycle.
- s_wready  in  NUM_SLAVES  write accepted, one cycle.
- err_clr  in  1  clears the error record.
- err_valid  out  1  sticky error flag.
- err_addr  out  32  address of the first unacknowledged error.
- err_is_wr  out  1  1 if the recorded error was a write.

## Operation
- **Decode.** The selected slave is the lowest index i whose nibble matches mem_addr[31:28]. If no nibble matches, the access is unmapped.
- **States.** IDLE, RD_WAIT, WR_WAIT. Strobes are acted on only in IDLE.
- **Read (IDLE, mem_rstrb=1).**
  - s_ren[sel] is driven combinationally in the same cycle.
  - The index and address are latched; state goes to RD_WAIT.
  - An unmapped read drives no s_ren.
- **Write (IDLE, mem_wmask≠0).**
  - s_wen[sel] is driven in the same cycle.
  - If s_wready[sel] is high in that cycle, the write completes and state stays IDLE.
  - Otherwise state goes to WR_WAIT.
  - An unmapped write is dropped and goes to WR_WAIT.
- **Read and write together.** The write wins and the read is dropped.
- **RD_WAIT.**
  - s_rvalid[sel_q] loads mem_rdata from s_rdata[sel_q]; state goes to IDLE.
  - The unmapped or timeout path loads ERR_DATA and writes the error record.
- **WR_WAIT.** Ends on s_wready[sel_q], or on the unmapped or timeout path.
- **Wait counter.**
  - Cleared on entry to either wait state and incremented each wait cycle.
  - Width is $clog2(TIMEOUT+1).
  - Timeout fires when the count reaches TIMEOUT.
  - Unmapped accesses complete after exactly one wait cycle.
- **Stale responses.** s_rvalid/s_wready seen in IDLE, or from a non-selected slave, are ignored. This includes a late response after a timeout.
- **Error record.**
  - Loaded only when err_valid=0: err_addr, err_is_wr, and err_valid set to 1.
  - err_clr clears err_valid.
  - If err_clr and a new error occur in the same cycle, the new error is recorded.

## Timing
- **Reset values.** state=IDLE, mem_rdata=0, mem_rbusy=0, mem_wbusy=0, s_ren=0, s_wen=0, err_valid=0, err_addr=0, err_is_wr=0, counter=0.
- **Reset mid-transaction.** The transaction is abandoned and no completion is delivered.
- **Stall signals.** mem_rbusy = (state==RD_WAIT); mem_wbusy = (state==WR_WAIT). Both come from registered state only.
- **Read latency.** mem_rstrb at cycle T and s_rvalid at T+k (k≥1) give mem_rbusy high for cycles T+1..T+k. mem_rdata is valid and mem_rbusy low at T+k+1.
- **Registered RAM (k=1).** Exactly one busy cycle.
- **Timeout.** Busy for TIMEOUT cycles, then ERR_DATA is delivered.
- **Write latency.** Zero stall when wready arrives in the strobe cycle. Otherwise mem_wbusy is high from T+1 until the cycle of wready, inclusive.
- **Strobe width.** s_ren/s_wen are exactly one cycle per request.

## Structure
- **Package soc_bus_pkg** holds:
  - the state enum (IDLE, RD_WAIT, WR_WAIT);
  - the ERR_DATA default;
  - slave index constants SLV_MEM=0, SLV_GPIO=1, SLV_UART=2;
  - the default SLAVE_BASE.
- **Sub-module bus_addr_decode** (combinational) takes mem_addr[31:28] and SLAVE_BASE. It outputs the one-hot hit, the hit index and the unmapped flag, with lowest-index priority.
- **The fabric itself** contains the FSM, counter, read-data register and error record.

## Test plan
- **Registered RAM read.** Read of 0x0000_0010 on slave 0 with 1-cycle rvalid returning 0x1234_5678 → mem_rbusy high for 1 cycle; mem_rdata=0x1234_5678 at T+2; s_ren=4'b0001 for one cycle.
- **Slow slave read.** Read of 0x2000_0004 on a UART model with rvalid at T+5 → 5 busy cycles; s_addr=0x0000_0004; data delivered at T+6.
- **Writes.** Write of 0x1000_0000 with wmask=4'b0001 and same-cycle wready → mem_wbusy never asserted; s_wen=4'b0010. Repeat with wready at T+3 → wbusy high T+1..T+3.
- **Unmapped read.** Read of 0xF000_0000 → one busy cycle; mem_rdata=0xDEAD_BEEF; err_valid=1, err_addr=0xF000_0000, err_is_wr=0. A second error leaves the record unchanged. err_clr followed by a new error in the same cycle records the new one.
- **Timeout.** Silent slave with TIMEOUT=8 → 8 busy cycles, then ERR_DATA; a late rvalid at T+12 is ignored and a following normal read is correct.
- **Reset mid-read.** Assert reset_n=0 during RD_WAIT → all outputs go to reset values asynchronously; the next read after release completes normally.
